// File: rtl/key_matrix_pkg.sv
// Shared definitions for the key matrix scanner: FSM encoding, event word layout and store depth.
package key_matrix_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_t;

    localparam int KM_N_BITS  = 2;
    localparam int KM_M_BITS  = 2;

    // Event word is {press, addr}, press in the MSB.
    localparam int EVT_W      = KM_N_BITS + KM_M_BITS + 1;

    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO with a valid/ready pop side and a full flag; depth 1 acts as a single register.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << PW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push is accepted into a full store when the head leaves in the same cycle.
    assign do_pop    = (count != '0) && pop_ready;
    assign do_push   = push && ((count != FULL_CNT) || do_pop);
    assign full      = (count == FULL_CNT);
    assign pop_valid = (count != '0);
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_matrix.sv
// Row-scanning switch matrix reader with per-key debounce and press/release events (addr = n + m*KEYS_N).
// Build option KEY_MATRIX_FIFO_EN: 4-deep event FIFO instead of a single event register.
module key_matrix
    import key_matrix_pkg::*;
#(
    parameter int KEYS_N        = 4,
    parameter int KEYS_M        = 2,
    parameter int N_BITS        = KM_N_BITS,
    parameter int M_BITS        = KM_M_BITS,
    parameter int SETTLE_CYCLES = 4,
    parameter int SET_BITS      = 3,
    parameter int DB_COUNT      = 3,
    parameter int DB_BITS       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [KEYS_N-1:0]        row_drv,
    input  logic [KEYS_M-1:0]        col_sense,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [N_BITS+M_BITS-1:0] evt_addr,
    output logic                     evt_press,
    output logic [KEYS_N*KEYS_M-1:0] key_state,
    output logic                     scan_done_tick
);
    localparam int AW    = N_BITS + M_BITS;
    localparam int EW    = EVT_W + (N_BITS - KM_N_BITS) + (M_BITS - KM_M_BITS);
    localparam int NKEYS = KEYS_N * KEYS_M;
`ifdef KEY_MATRIX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int STORE_DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
    localparam logic [DB_BITS:0] DB_LAST = (DB_BITS + 1)'(DB_COUNT);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [N_BITS-1:0]   row_idx;
    logic [N_BITS-1:0]   row_nxt;
    logic [M_BITS-1:0]   col_idx;
    logic [M_BITS-1:0]   col_nxt;
    logic [SET_BITS-1:0] settle_cnt;
    logic [SET_BITS-1:0] settle_nxt;
    logic [KEYS_M-1:0]   col_sync1;
    logic [KEYS_M-1:0]   col_sync2;
    logic [KEYS_M-1:0]   samp;
    logic [DB_BITS-1:0]  db_cnt [NKEYS];
    logic [KEYS_N-1:0]   row_onehot;

    logic [AW-1:0]       scan_addr;
    logic                raw_bit;
    logic                cur_state;
    logic [DB_BITS-1:0]  cur_cnt;
    logic [DB_BITS:0]    cnt_plus;

    logic                latch_samp;
    logic                cnt_wr;
    logic [DB_BITS-1:0]  cnt_val;
    logic                flip;
    logic                evt_push;
    logic                tick_nxt;
    logic                advance;

    logic                store_full;
    logic                pop_fire;
    logic                can_push;
    logic [EW-1:0]       push_word;
    logic [EW-1:0]       head_word;

    // Select the key under the scan pointer; loops avoid indexing narrow vectors with wider indices.
    always_comb begin
        scan_addr = AW'(row_idx) + AW'(col_idx) * AW'(KEYS_N);
        raw_bit   = 1'b0;
        cur_state = 1'b0;
        cur_cnt   = '0;
        for (int m = 0; m < KEYS_M; m++) begin
            if (M_BITS'(m) == col_idx) begin
                raw_bit = samp[m];
            end
        end
        for (int k = 0; k < NKEYS; k++) begin
            if (AW'(k) == scan_addr) begin
                cur_state = key_state[k];
                cur_cnt   = db_cnt[k];
            end
        end
        cnt_plus = {1'b0, cur_cnt} + (DB_BITS + 1)'(1);
    end

    assign pop_fire  = evt_valid && evt_ready;
    assign can_push  = !store_full || pop_fire;
    assign push_word = {~cur_state, scan_addr};

    always_comb begin
        state_nxt  = state;
        row_nxt    = row_idx;
        col_nxt    = col_idx;
        settle_nxt = settle_cnt;
        latch_samp = 1'b0;
        cnt_wr     = 1'b0;
        cnt_val    = '0;
        flip       = 1'b0;
        evt_push   = 1'b0;
        tick_nxt   = 1'b0;
        advance    = 1'b0;
        unique case (state)
            ST_DRIVE: begin
                if (settle_cnt == SET_BITS'(SETTLE_CYCLES - 1)) begin
                    latch_samp = 1'b1;
                    settle_nxt = '0;
                    col_nxt    = '0;
                    state_nxt  = ST_SCAN;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            ST_SCAN: begin
                advance = 1'b1;
                if (raw_bit == cur_state) begin
                    cnt_wr  = 1'b1;
                    cnt_val = '0;
                end else if (cnt_plus == DB_LAST) begin
                    // A full store freezes the scan on this key so the event is retried, not lost.
                    if (can_push) begin
                        evt_push = 1'b1;
                        flip     = 1'b1;
                        cnt_wr   = 1'b1;
                        cnt_val  = '0;
                    end else begin
                        advance = 1'b0;
                    end
                end else begin
                    cnt_wr  = 1'b1;
                    cnt_val = cur_cnt + 1'b1;
                end
                if (advance) begin
                    if (col_idx == M_BITS'(KEYS_M - 1)) begin
                        col_nxt    = '0;
                        settle_nxt = '0;
                        state_nxt  = ST_DRIVE;
                        if (row_idx == N_BITS'(KEYS_N - 1)) begin
                            row_nxt  = '0;
                            tick_nxt = 1'b1;
                        end else begin
                            row_nxt = row_idx + 1'b1;
                        end
                    end else begin
                        col_nxt = col_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_DRIVE;
            end
        endcase
    end

    always_comb begin
        row_onehot = '0;
        for (int n = 0; n < KEYS_N; n++) begin
            row_onehot[n] = (row_nxt == N_BITS'(n));
        end
    end

    // row_drv is registered from the next row index so it tracks the FSM and stays low in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_DRIVE;
            row_idx        <= '0;
            col_idx        <= '0;
            settle_cnt     <= '0;
            row_drv        <= '0;
            scan_done_tick <= 1'b0;
        end else begin
            state          <= state_nxt;
            row_idx        <= row_nxt;
            col_idx        <= col_nxt;
            settle_cnt     <= settle_nxt;
            row_drv        <= row_onehot;
            scan_done_tick <= tick_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_sync1 <= '0;
            col_sync2 <= '0;
            samp      <= '0;
        end else begin
            col_sync1 <= col_sense;
            col_sync2 <= col_sync1;
            if (latch_samp) begin
                samp <= col_sync2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_state <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                if (AW'(k) == scan_addr) begin
                    if (cnt_wr) begin
                        db_cnt[k] <= cnt_val;
                    end
                    if (flip) begin
                        key_state[k] <= ~key_state[k];
                    end
                end
            end
        end
    end

    key_evt_fifo #(
        .DEPTH (STORE_DEPTH),
        .WIDTH (EW)
    ) u_evt_store (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (push_word),
        .full      (store_full),
        .pop_valid (evt_valid),
        .pop_ready (evt_ready),
        .pop_data  (head_word)
    );

    assign evt_press = head_word[EW-1];
    assign evt_addr  = head_word[AW-1:0];

endmodule

// File: tb/tb_key_matrix.sv
// Bench for key_matrix: modelled switch matrix, row timing table plus event/debounce/stall sequences.
module tb_key_matrix;

    typedef struct {
        int         cyc;
        logic [3:0] row;
        logic       tick;
    } row_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_drv;
    logic [1:0] col_sense;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_addr;
    logic       evt_press;
    logic [7:0] key_state;
    logic       scan_done_tick;

    logic [7:0] closed;
    row_vec_t   row_tab [12];
    int         n_checks = 0;
    int         n_pass = 0;
    int         ev_total = 0;
    int         cur;
    int         waited;
    bit         got;
    int         base;
    int         changes;
    logic [3:0] snapshot;
    int         n_log;
    logic [3:0] evt_log [8];
    logic [3:0] exp_order [5];

    key_matrix dut (
        .clk            (clk),
        .reset          (reset),
        .row_drv        (row_drv),
        .col_sense      (col_sense),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_addr       (evt_addr),
        .evt_press      (evt_press),
        .key_state      (key_state),
        .scan_done_tick (scan_done_tick)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed key connects its row line to its column line.
    assign col_sense[0] = |(row_drv & closed[3:0]);
    assign col_sense[1] = |(row_drv & closed[7:4]);

    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            ev_total <= ev_total + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] keys, input logic rdy);
        closed    = keys;
        evt_ready = rdy;
    endtask

    task automatic wait_evt(input int limit, output int w, output bit seen);
        w = 0;
        while (!evt_valid && w < limit) begin
            @(negedge clk);
            w++;
        end
        seen = evt_valid;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done_tick && n < 30);
        check_output("tick_seen", 32'(scan_done_tick), 32'd1);
    endtask

    initial begin
        row_tab[0]  = '{0,  4'b0001, 1'b0};
        row_tab[1]  = '{4,  4'b0001, 1'b0};
        row_tab[2]  = '{5,  4'b0010, 1'b0};
        row_tab[3]  = '{10, 4'b0010, 1'b0};
        row_tab[4]  = '{11, 4'b0100, 1'b0};
        row_tab[5]  = '{16, 4'b0100, 1'b0};
        row_tab[6]  = '{17, 4'b1000, 1'b0};
        row_tab[7]  = '{22, 4'b1000, 1'b0};
        row_tab[8]  = '{23, 4'b0001, 1'b1};
        row_tab[9]  = '{24, 4'b0001, 1'b0};
        row_tab[10] = '{28, 4'b0001, 1'b0};
        row_tab[11] = '{29, 4'b0010, 1'b0};
        exp_order[0] = 4'd0;
        exp_order[1] = 4'd4;
        exp_order[2] = 4'd1;
        exp_order[3] = 4'd2;
        exp_order[4] = 4'd3;

        apply_stimulus(8'h00, 1'b0);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        check_output("rst_row_drv", 32'(row_drv), 32'd0);
        check_output("rst_evt_valid", 32'(evt_valid), 32'd0);
        check_output("rst_key_state", 32'(key_state), 32'd0);
        check_output("rst_evt_addr", 32'(evt_addr), 32'd0);
        check_output("rst_tick", 32'(scan_done_tick), 32'd0);

        // Row sequencing after reset release
        reset = 1'b1;
        cur = -1;
        for (int i = 0; i < 12; i++) begin
            while (cur < row_tab[i].cyc) begin
                @(negedge clk);
                cur++;
            end
            check_output($sformatf("row_drv_c%0d", row_tab[i].cyc), 32'(row_drv), 32'(row_tab[i].row));
            check_output($sformatf("tick_c%0d", row_tab[i].cyc), 32'(scan_done_tick), 32'(row_tab[i].tick));
        end

        // Press then release of key 6 (row 2, column 1)
        apply_stimulus(8'h40, 1'b1);
        wait_evt(110, waited, got);
        check_output("press6_seen", 32'(got), 32'd1);
        check_output("press6_latency", 32'(waited >= 40 && waited <= 100), 32'd1);
        check_output("press6_addr", 32'(evt_addr), 32'd6);
        check_output("press6_press", 32'(evt_press), 32'd1);
        check_output("press6_state", 32'(key_state), 32'h40);
        @(negedge clk);
        check_output("press6_popped", 32'(evt_valid), 32'd0);
        apply_stimulus(8'h00, 1'b1);
        wait_evt(110, waited, got);
        check_output("rel6_seen", 32'(got), 32'd1);
        check_output("rel6_addr", 32'(evt_addr), 32'd6);
        check_output("rel6_press", 32'(evt_press), 32'd0);
        check_output("rel6_state", 32'(key_state), 32'h00);
        @(negedge clk);

        // Two 2-scan bounces separated by open scans must never fire
        wait_tick();
        base = ev_total;
        apply_stimulus(8'h40, 1'b1);
        wait_tick();
        wait_tick();
        apply_stimulus(8'h00, 1'b1);
        wait_tick();
        wait_tick();
        apply_stimulus(8'h40, 1'b1);
        wait_tick();
        wait_tick();
        apply_stimulus(8'h00, 1'b1);
        wait_tick();
        wait_tick();
        wait_tick();
        check_output("bounce_no_evt", 32'(ev_total - base), 32'd0);
        check_output("bounce_key6", 32'(key_state[6]), 32'd0);

        // Keys 1 and 5 share row 1: back-to-back events, pop and push in one cycle
        wait_tick();
        apply_stimulus(8'h22, 1'b1);
        wait_evt(110, waited, got);
        check_output("b2b_first_seen", 32'(got), 32'd1);
        check_output("b2b_first_addr", 32'(evt_addr), 32'd1);
        @(negedge clk);
        check_output("b2b_second_valid", 32'(evt_valid), 32'd1);
        check_output("b2b_second_addr", 32'(evt_addr), 32'd5);
        check_output("b2b_second_press", 32'(evt_press), 32'd1);
        @(negedge clk);
        check_output("b2b_drained", 32'(evt_valid), 32'd0);
        check_output("b2b_state", 32'(key_state), 32'h22);

        apply_stimulus(8'h00, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
`ifndef KEY_MATRIX_FIFO_EN
        // Single-register store: event for key 0 held, scan stalls on key 5
        apply_stimulus(8'h21, 1'b0);
        reset = 1'b1;
        wait_evt(110, waited, got);
        check_output("stall_first_seen", 32'(got), 32'd1);
        check_output("stall_first_addr", 32'(evt_addr), 32'd0);
        repeat (10) @(negedge clk);
        snapshot = row_drv;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (row_drv !== snapshot) changes++;
        end
        check_output("stall_row_const", 32'(changes), 32'd0);
        check_output("stall_row_drv", 32'(snapshot), 32'b0010);
        check_output("stall_held_valid", 32'(evt_valid), 32'd1);
        check_output("stall_held_addr", 32'(evt_addr), 32'd0);
        check_output("stall_state", 32'(key_state), 32'h01);
        apply_stimulus(8'h21, 1'b1);
        @(negedge clk);
        check_output("resume_valid", 32'(evt_valid), 32'd1);
        check_output("resume_addr", 32'(evt_addr), 32'd5);
        check_output("resume_press", 32'(evt_press), 32'd1);
        check_output("resume_state", 32'(key_state), 32'h21);
        @(negedge clk);
        check_output("resume_drained", 32'(evt_valid), 32'd0);
        waited = 0;
        while (row_drv === 4'b0010 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output("resume_row_moved", 32'(row_drv !== 4'b0010), 32'd1);
`else
        // FIFO store: four events buffered, fifth key stalls the scan
        apply_stimulus(8'h1F, 1'b0);
        reset = 1'b1;
        wait_evt(110, waited, got);
        check_output("fifo_first_seen", 32'(got), 32'd1);
        repeat (40) @(negedge clk);
        check_output("fifo_stall_row", 32'(row_drv), 32'b1000);
        check_output("fifo_head_addr", 32'(evt_addr), 32'd0);
        check_output("fifo_stall_state", 32'(key_state), 32'h17);
        apply_stimulus(8'h1F, 1'b1);
        n_log = 0;
        for (int c = 0; c < 12; c++) begin
            if (evt_valid && n_log < 8) begin
                evt_log[n_log] = evt_addr;
                n_log++;
            end
            @(negedge clk);
        end
        check_output("fifo_evt_count", 32'(n_log), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("fifo_order_%0d", i), 32'(evt_log[i]), 32'(exp_order[i]));
        end
        check_output("fifo_all_pressed", 32'(key_state), 32'h1F);
`endif

        // Stall again on release events, then reset in the middle of the stall
        wait_tick();
        apply_stimulus(8'h00, 1'b0);
        repeat (100) @(negedge clk);
        check_output("midstall_valid", 32'(evt_valid), 32'd1);
        check_output("midstall_addr", 32'(evt_addr), 32'd0);
        check_output("midstall_press", 32'(evt_press), 32'd0);
`ifndef KEY_MATRIX_FIFO_EN
        check_output("midstall_state", 32'(key_state), 32'h20);
`else
        check_output("midstall_state", 32'(key_state), 32'h08);
`endif
        reset = 1'b0;
        #1;
        check_output("midrst_row_drv", 32'(row_drv), 32'd0);
        check_output("midrst_valid", 32'(evt_valid), 32'd0);
        check_output("midrst_addr", 32'(evt_addr), 32'd0);
        check_output("midrst_press", 32'(evt_press), 32'd0);
        check_output("midrst_state", 32'(key_state), 32'd0);
        check_output("midrst_tick", 32'(scan_done_tick), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
